// File: rtl/io_input_conditioner.sv
// io_input_conditioner
//
// Input stage for the data-memory IO block. Raw slide switches and push
// buttons are polarity-normalised, passed through a 2-flop synchroniser and
// debounced per bit. The result is the 14-bit (by default) io_input_bus
// sampled by the memory-mapped IO read path.
//
// Ports:
//   clock         system clock, all logic on posedge
//   reset         synchronous, active-high reset
//   sw_raw        asynchronous slide switch inputs, active-high
//   btn_raw       asynchronous push buttons, polarity set by BTN_ACTIVE_LOW
//   io_input_bus  [SW_WIDTH-1:0] debounced switches,
//                 [SW_WIDTH+i]   debounced button i (1 = pressed)
//   btn_press     one-cycle pulse per accepted button press
//   stable        high once the post-reset settle time has elapsed
//
// Optional build macro: IO_INPUT_TOGGLE_EN
//   When defined, io_input_bus[SW_WIDTH+i] carries a toggle flop that flips
//   on every btn_press[i] pulse instead of the debounced button level.
//   Switch bits, btn_press and stable are identical in both builds.

module io_input_conditioner #(
  parameter int SW_WIDTH        = 10,
  parameter int BTN_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [SW_WIDTH-1:0]           sw_raw,
  input  logic [BTN_WIDTH-1:0]          btn_raw,
  output logic [SW_WIDTH+BTN_WIDTH-1:0] io_input_bus,
  output logic [BTN_WIDTH-1:0]          btn_press,
  output logic                          stable
);

  localparam int N     = SW_WIDTH + BTN_WIDTH;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int SET_W = $clog2(DEBOUNCE_CYCLES + 3);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // stable rises on the (DEBOUNCE_CYCLES+3)-th edge after reset release,
  // i.e. when the counter already holds DEBOUNCE_CYCLES+2 before that edge.
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(DEBOUNCE_CYCLES + 2);

  logic [BTN_WIDTH-1:0] btn_norm;
  logic [N-1:0]         raw_p0;
  logic [N-1:0]         sync_p1;
  logic [N-1:0]         sync_p2;
  logic [N-1:0]         deb_p3;
  logic [CNT_W-1:0]     cnt_p3 [N];
  logic [N-1:0]         accept;
  logic [BTN_WIDTH-1:0] rise_btn;
  logic [BTN_WIDTH-1:0] press_next;
  logic [SET_W-1:0]     settle_cnt;

  // ---- stage p0: polarity normalisation (everything after is active-high)
  assign btn_norm = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
  assign raw_p0   = {btn_norm, sw_raw};

  // ---- stage p1/p2: two-flop synchroniser
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p1 <= raw_p0;
      sync_p2 <= sync_p1;
    end
  end

  // ---- stage p3: per-bit debounce
  // A bit is accepted on the edge where it has disagreed with deb for
  // DEBOUNCE_CYCLES consecutive edges; any agreement clears the count.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = (sync_p2[i] != deb_p3[i]) && (cnt_p3[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      deb_p3 <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_p3[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync_p2[i] == deb_p3[i]) begin
          cnt_p3[i] <= '0;
        end else if (accept[i]) begin
          deb_p3[i] <= sync_p2[i];
          cnt_p3[i] <= '0;
        end else begin
          cnt_p3[i] <= cnt_p3[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---- stage p4: press pulses and settle flag
  // Only 0->1 acceptances pulse, and only once the settle time is over, so
  // buttons held through reset never generate a phantom press.
  assign rise_btn   = accept[N-1:SW_WIDTH] & sync_p2[N-1:SW_WIDTH];
  assign press_next = rise_btn & {BTN_WIDTH{stable}};

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_press  <= '0;
      settle_cnt <= '0;
      stable     <= 1'b0;
    end else begin
      btn_press <= press_next;
      if (!stable) begin
        if (settle_cnt == SET_LAST) begin
          stable <= 1'b1;
        end else begin
          settle_cnt <= settle_cnt + SET_W'(1);
        end
      end
    end
  end

`ifdef IO_INPUT_TOGGLE_EN
  logic [BTN_WIDTH-1:0] toggle_p4;

  // Toggle flips on the same edge btn_press is registered, so the bus bit
  // changes in the cycle the pulse is visible.
  always_ff @(posedge clock) begin
    if (reset) begin
      toggle_p4 <= '0;
    end else begin
      toggle_p4 <= toggle_p4 ^ press_next;
    end
  end

  assign io_input_bus = {toggle_p4, deb_p3[SW_WIDTH-1:0]};
`else
  assign io_input_bus = deb_p3;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
module tb_io_input_conditioner;

  localparam int SW_WIDTH  = 10;
  localparam int BTN_WIDTH = 4;
  localparam int DEB       = 4;
  localparam int N         = SW_WIDTH + BTN_WIDTH;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [SW_WIDTH-1:0]  sw_raw;
  logic [BTN_WIDTH-1:0] btn_raw;
  logic [N-1:0]         io_input_bus;
  logic [BTN_WIDTH-1:0] btn_press;
  logic                 stable;

  io_input_conditioner #(
    .SW_WIDTH       (SW_WIDTH),
    .BTN_WIDTH      (BTN_WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .BTN_ACTIVE_LOW (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sw_raw      (sw_raw),
    .btn_raw     (btn_raw),
    .io_input_bus(io_input_bus),
    .btn_press   (btn_press),
    .stable      (stable)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0]         bus;
    logic [BTN_WIDTH-1:0] press;
    logic                 stb;
    string                tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int n_press  = 0;

  // Reference state: edges since reset release and the normalised raw value
  // sampled at each of those edges (m_hist[0] = edge 1).
  int           m_edge;
  logic [N-1:0] m_hist[$];
  logic [N-1:0] m_deb;
  logic         m_stable;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Value the synchroniser presents to the debouncer just before edge x:
  // the raw sample from two edges earlier, or 0 right after reset.
  function automatic logic [N-1:0] s_at(input int x);
    if (x >= 3) return m_hist[x-3];
    return '0;
  endfunction

  // Drive one cycle of stimulus and push the outputs expected after the
  // edge that samples it. A debounced bit flips once the last DEB
  // synchroniser values since release all disagree with it.
  task automatic tick(input logic r, input logic [SW_WIDTH-1:0] sw,
                      input logic [BTN_WIDTH-1:0] btn, input string tag);
    exp_t                 e;
    logic [N-1:0]         nd;
    logic [N-1:0]         sv;
    logic [BTN_WIDTH-1:0] pr;
    bit                   all_diff;
    reset   = r;
    sw_raw  = sw;
    btn_raw = btn;
    pr      = '0;
    if (r) begin
      m_edge   = 0;
      m_hist.delete();
      m_deb    = '0;
      m_stable = 1'b0;
    end else begin
      m_edge++;
      m_hist.push_back({~btn, sw});
      nd = m_deb;
      if (m_edge >= DEB) begin
        for (int b = 0; b < N; b++) begin
          all_diff = 1'b1;
          for (int j = 0; j < DEB; j++) begin
            sv = s_at(m_edge - j);
            if (sv[b] == m_deb[b]) all_diff = 1'b0;
          end
          if (all_diff) begin
            nd[b] = ~m_deb[b];
            if (b >= SW_WIDTH && nd[b] && m_stable) pr[b-SW_WIDTH] = 1'b1;
          end
        end
      end
      m_deb = nd;
      if (m_edge >= DEB + 3) m_stable = 1'b1;
    end
    e.bus   = m_deb;
    e.press = pr;
    e.stb   = m_stable;
    e.tag   = tag;
    sb.push_back(e);
    @(negedge clock);
  endtask

  task automatic hold(input int n, input logic [SW_WIDTH-1:0] sw,
                      input logic [BTN_WIDTH-1:0] btn, input string tag);
    repeat (n) tick(1'b0, sw, btn, tag);
  endtask

  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk_eq({mon_e.tag, "/bus"},    32'(io_input_bus), 32'(mon_e.bus));
      chk_eq({mon_e.tag, "/press"},  32'(btn_press),    32'(mon_e.press));
      chk_eq({mon_e.tag, "/stable"}, 32'(stable),       32'(mon_e.stb));
      n_press += $countones(btn_press);
    end
  end

  initial begin
    // Reset with all buttons released (raw high) and switches low
    repeat (3) tick(1'b1, 10'h000, 4'hF, "reset");
    hold(12, 10'h000, 4'hF, "settle");

    // Switch 3 rises and stays
    hold(9, 10'h008, 4'hF, "sw3");

    // Two 3-cycle glitches on switch 0, separated by a short gap
    hold(3, 10'h009, 4'hF, "glitch_a");
    hold(2, 10'h008, 4'hF, "glitch_gap");
    hold(3, 10'h009, 4'hF, "glitch_b");
    hold(8, 10'h008, 4'hF, "glitch_end");

    // Button 1 pressed for 12 cycles then released
    hold(12, 10'h008, 4'hD, "btn1_press");
    hold(8,  10'h008, 4'hF, "btn1_release");

    // Switch 7 and button 2 change together
    hold(7, 10'h088, 4'hB, "simul");
    hold(7, 10'h008, 4'hF, "simul_back");

    // Switch 5 changes, reset lands mid-count, input held afterwards
    tick(1'b0, 10'h028, 4'hF, "rst_mid");
    tick(1'b0, 10'h028, 4'hF, "rst_mid");
    tick(1'b1, 10'h028, 4'hF, "rst_mid_rst");
    hold(10, 10'h028, 4'hF, "rst_mid_after");

    // Button 0 held through reset, then released and pressed again
    repeat (2) tick(1'b1, 10'h000, 4'hE, "held_btn_rst");
    hold(10, 10'h000, 4'hE, "held_btn");
    hold(8,  10'h000, 4'hF, "held_release");
    hold(8,  10'h000, 4'hE, "repress");
    hold(4,  10'h000, 4'hF, "tail");

    #1;
    chk_eq("sb_drain", 32'(sb.size()), 32'd0);
    // btn1 press, btn2 press and the button 0 re-press; nothing else.
    chk_eq("press_count", 32'(n_press), 32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
